// File: rtl/systolic_feeder_4x4.sv
// Operand sequencer for the 4x4 broadcast MAC array: buffers A and B, clears the
// array, streams A columns / B rows for four steps, drains, then pulses done.
module systolic_feeder_4x4 #(
  parameter int DW     = 8,
  parameter int PE_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [3:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pe_rst,
  output logic [DW-1:0] a1,
  output logic [DW-1:0] a2,
  output logic [DW-1:0] a3,
  output logic [DW-1:0] a4,
  output logic [DW-1:0] b1,
  output logic [DW-1:0] b2,
  output logic [DW-1:0] b3,
  output logic [DW-1:0] b4
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(PE_LAT - 1);

  state_t        state_reg, state_next;
  logic [2:0]    step_reg, step_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          pe_rst_reg, pe_rst_next;
  logic          load_ops;
  logic [1:0]    col;
  logic [DW-1:0] buf_a [16];
  logic [DW-1:0] buf_b [16];
  logic [DW-1:0] a_out [4];
  logic [DW-1:0] b_out [4];

  // Buffers are plain storage with no reset; writes are locked out while a run is active.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_reg) begin
      if (wr_sel) buf_b[wr_addr] <= wr_data;
      else        buf_a[wr_addr] <= wr_data;
    end
  end

  // Next-state logic also decides what the registered outputs become on the next edge.
  always_comb begin
    state_next  = state_reg;
    step_next   = step_reg;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    pe_rst_next = 1'b0;
    load_ops    = 1'b0;
    col         = 2'd0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = CLEAR;
          busy_next   = 1'b1;
          pe_rst_next = 1'b1;
        end
      end
      CLEAR: begin
        state_next = FEED;
        step_next  = 3'd0;
        busy_next  = 1'b1;
        load_ops   = 1'b1;
        col        = 2'd0;
      end
      FEED: begin
        busy_next = 1'b1;
        if (step_reg[1:0] == 2'd3) begin
          state_next = DRAIN;
          step_next  = 3'd0;
        end else begin
          step_next = step_reg + 3'd1;
          load_ops  = 1'b1;
          col       = step_reg[1:0] + 2'd1;
        end
      end
      DRAIN: begin
        busy_next = 1'b1;
        if (step_reg == DRAIN_LAST) begin
          state_next = DONE;
          step_next  = 3'd0;
          done_next  = 1'b1;
        end else begin
          step_next = step_reg + 3'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
        step_next  = 3'd0;
      end
      default: begin
        state_next = IDLE;
        step_next  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      step_reg   <= 3'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      pe_rst_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      step_reg   <= step_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      pe_rst_reg <= pe_rst_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [DW-1:0] a_reg, a_next, b_reg, b_next;

      // Lane gi carries row gi of A and column gi of B at the current step.
      always_comb begin
        a_next = '0;
        b_next = '0;
        if (load_ops) begin
          a_next = buf_a[{LANE, col}];
          b_next = buf_b[{col, LANE}];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_reg <= '0;
          b_reg <= '0;
        end else begin
          a_reg <= a_next;
          b_reg <= b_next;
        end
      end

      assign a_out[gi] = a_reg;
      assign b_out[gi] = b_reg;
    end
  endgenerate

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign pe_rst = pe_rst_reg;
  assign a1 = a_out[0];
  assign a2 = a_out[1];
  assign a3 = a_out[2];
  assign a4 = a_out[3];
  assign b1 = b_out[0];
  assign b2 = b_out[1];
  assign b3 = b_out[2];
  assign b4 = b_out[3];

endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// Bench for systolic_feeder_4x4: a behavioural MAC array accumulates the streamed
// operands and is compared against a plain matrix product of the written buffers.
module tb_systolic_feeder_4x4;

  localparam int DW     = 8;
  localparam int PE_LAT = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          wr_sel = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          busy, done, pe_rst;
  logic [DW-1:0] a1, a2, a3, a4, b1, b2, b3, b4;

  int total  = 0;
  int passed = 0;

  int unsigned     ma [4][4];
  int unsigned     mb [4][4];
  longint unsigned acc [4][4];
  wire [DW-1:0]    a_v [4];
  wire [DW-1:0]    b_v [4];

  systolic_feeder_4x4 #(.DW(DW), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .pe_rst(pe_rst),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .b1(b1), .b2(b2), .b3(b3), .b4(b4)
  );

  always #5 clk = ~clk;

  assign a_v[0] = a1; assign a_v[1] = a2; assign a_v[2] = a3; assign a_v[3] = a4;
  assign b_v[0] = b1; assign b_v[1] = b2; assign b_v[2] = b3; assign b_v[3] = b4;

  // Stand-in for the broadcast MAC array with a one-cycle accumulate latency.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (rst || pe_rst) acc[i][j] <= 0;
        else acc[i][j] <= acc[i][j] + longint'(a_v[i]) * longint'(b_v[j]);
  end

  function automatic longint unsigned ref_c(input int i, input int j);
    longint unsigned s = 0;
    for (int k = 0; k < 4; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
    return s;
  endfunction

  function automatic logic [8*DW-1:0] exp_ops(input int k);
    logic [8*DW-1:0] v = '0;
    if (k >= 0)
      for (int i = 0; i < 4; i++) begin
        v[(7-i)*DW +: DW] = DW'(ma[i][k]);
        v[(3-i)*DW +: DW] = DW'(mb[k][i]);
      end
    return v;
  endfunction

  function automatic logic [8*DW-1:0] got_ops();
    return {a1, a2, a3, a4, b1, b2, b3, b4};
  endfunction

  task automatic write_elem(input logic sel, input int r, input int c, input int unsigned v);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(r * 4 + c); wr_data = DW'(v);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_all(input bit skip_last_b);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        write_elem(1'b0, r, c, ma[r][c]);
        if (!(skip_last_b && r == 3 && c == 3)) write_elem(1'b1, r, c, mb[r][c]);
      end
  endtask

  // One full run from start; optional write alongside start, optional stray start/write in FEED.
  task automatic run_check(input string tag, input bit chain, input int inj_k,
                           input bit with_wr, input logic [3:0] ws_addr);
    int busy_cnt = 0;
    start = 1'b1;
    if (with_wr) begin
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = ws_addr; wr_data = DW'(mb[ws_addr[3:2]][ws_addr[1:0]]);
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    total++;
    if ({pe_rst, busy, done, got_ops()} !== {1'b1, 1'b1, 1'b0, exp_ops(-1)})
      $display("FAIL %s clear: pe_rst=%b busy=%b done=%b ops=%h required 1 1 0 zero", tag, pe_rst, busy, done, got_ops());
    else passed++;
    if (busy && !done) busy_cnt++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      total++;
      if ({pe_rst, busy, done, got_ops()} !== {1'b0, 1'b1, 1'b0, exp_ops(k)})
        $display("FAIL %s feed%0d: pe_rst=%b busy=%b done=%b ops=%h required ops=%h", tag, k, pe_rst, busy, done, got_ops(), exp_ops(k));
      else passed++;
      if (busy && !done) busy_cnt++;
      if (k == inj_k) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = DW'(99);
      end
    end
    for (int d = 0; d < PE_LAT; d++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      total++;
      if ({busy, done, got_ops()} !== {1'b1, 1'b0, exp_ops(-1)})
        $display("FAIL %s drain: busy=%b done=%b ops=%h required 1 0 zero", tag, busy, done, got_ops());
      else passed++;
      if (busy && !done) busy_cnt++;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    total++;
    if ({busy, done} !== 2'b11) $display("FAIL %s done: busy=%b done=%b required 1 1", tag, busy, done);
    else passed++;
    total++;
    if (busy_cnt != 5 + PE_LAT) $display("FAIL %s busy_len: busy before done=%0d required %0d", tag, busy_cnt, 5 + PE_LAT);
    else passed++;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (acc[i][j] !== ref_c(i, j))
          $display("FAIL %s c%0d%0d: got %0d required %0d", tag, i + 1, j + 1, acc[i][j], ref_c(i, j));
        else passed++;
      end
    if (chain) start = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, pe_rst, got_ops()} !== {3'b000, exp_ops(-1)})
      $display("FAIL %s idle: busy=%b done=%b pe_rst=%b ops=%h required all zero", tag, busy, done, pe_rst, got_ops());
    else passed++;
    $display("run %s: c11=%0d c44=%0d", tag, acc[0][0], acc[3][3]);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    total++;
    if ({busy, done, pe_rst, got_ops()} !== {3'b000, exp_ops(-1)})
      $display("FAIL reset_hold: busy=%b done=%b pe_rst=%b ops=%h required all zero", busy, done, pe_rst, got_ops());
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, pe_rst, got_ops()} !== {3'b000, exp_ops(-1)})
      $display("FAIL reset_release: busy=%b done=%b pe_rst=%b ops=%h required all zero", busy, done, pe_rst, got_ops());
    else passed++;
    $display("reset: outputs idle");
  endtask

  task automatic test_identity();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = 4 * r + c + 1;
      end
    load_all(1'b0);
    run_check("identity", 1'b0, -1, 1'b0, 4'd0);
    total++;
    if (acc[3][2] !== 64'd15) $display("FAIL identity_c43: got %0d required 15", acc[3][2]);
    else passed++;
  endtask

  task automatic test_max_values();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin ma[r][c] = 255; mb[r][c] = 255; end
    load_all(1'b0);
    run_check("max", 1'b0, -1, 1'b0, 4'd0);
    total++;
    if (acc[1][2] !== 64'd260100) $display("FAIL max_c23: got %0d required 260100", acc[1][2]);
    else passed++;
  endtask

  task automatic test_clear_between_runs();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin ma[r][c] = 1; mb[r][c] = 1; end
    load_all(1'b0);
    run_check("ones", 1'b0, -1, 1'b0, 4'd0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin ma[r][c] = 2; mb[r][c] = 3; end
    load_all(1'b0);
    run_check("twos_threes", 1'b0, -1, 1'b0, 4'd0);
    total++;
    if (acc[0][3] !== 64'd24) $display("FAIL rerun_c14: got %0d required 24", acc[0][3]);
    else passed++;
  endtask

  task automatic test_ignore_in_feed();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = 4 * r + c + 1;
      end
    load_all(1'b0);
    run_check("feed_noise", 1'b0, 1, 1'b0, 4'd0);
    run_check("after_noise", 1'b0, -1, 1'b0, 4'd0);
  endtask

  task automatic test_mid_run_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin ma[r][c] = $urandom_range(0, 255); mb[r][c] = $urandom_range(0, 255); end
    load_all(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, pe_rst, got_ops()} !== {3'b000, exp_ops(-1)})
      $display("FAIL async_reset: busy=%b done=%b pe_rst=%b ops=%h required all zero", busy, done, pe_rst, got_ops());
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, pe_rst} !== 3'b000)
      $display("FAIL after_reset: busy=%b done=%b pe_rst=%b required 0 0 0", busy, done, pe_rst);
    else passed++;
    run_check("post_reset", 1'b0, -1, 1'b0, 4'd0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin ma[r][c] = $urandom_range(0, 255); mb[r][c] = $urandom_range(0, 255); end
    load_all(1'b0);
    run_check("b2b_first", 1'b1, -1, 1'b0, 4'd0);
    run_check("b2b_second", 1'b0, -1, 1'b0, 4'd0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin ma[r][c] = $urandom_range(0, 255); mb[r][c] = $urandom_range(0, 255); end
      load_all(1'b1);
      run_check($sformatf("random%0d", n), 1'b0, -1, 1'b1, 4'd15);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_max_values();
    test_clear_between_runs();
    test_ignore_in_feed();
    test_mid_run_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
